// File: rtl/wb_poller_pkg.sv
// Shared types and counter rules for the Wishbone button poller.
// Button index constants and the priority-ordered next-count function.
package wb_poller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT
    } poll_state_t;

    localparam int BTN_INC = 0;
    localparam int BTN_DEC = 1;
    localparam int BTN_CLR = 2;

    // Clear beats everything; inc and dec together cancel.
    function automatic logic [7:0] next_count(input logic [7:0] count, input logic [2:0] rise);
        logic [7:0] nxt;
        nxt = count;
        if (rise[BTN_CLR])
            nxt = 8'd0;
        else if (rise[BTN_INC] && rise[BTN_DEC])
            nxt = count;
        else if (rise[BTN_INC])
            nxt = count + 8'd1;
        else if (rise[BTN_DEC])
            nxt = count - 8'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/wb_single_master.sv
// One-request Wishbone pipelined master; request issued the cycle after start, done/timeout are combinational.
// stb is held through stall; the request is abandoned after TIMEOUT_CYCLES cycles of cyc without ack.
module wb_single_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        timeout,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_wdat,
    input  logic        wb_ack,
    input  logic        wb_stall,
    input  logic [31:0] wb_rdat
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_cnt;

    assign done    = wb_cyc && wb_ack;
    assign timeout = wb_cyc && !wb_ack && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign rdata   = wb_rdat;

    // A start on the ack cycle chains the next request without dropping cyc.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
            wb_we   <= 1'b0;
            wb_wdat <= '0;
            tmo_cnt <= '0;
        end else if (start) begin
            wb_cyc  <= 1'b1;
            wb_stb  <= 1'b1;
            wb_we   <= we;
            wb_wdat <= we ? wdata : '0;
            tmo_cnt <= '0;
        end else if (done || timeout) begin
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
            wb_we   <= 1'b0;
            wb_wdat <= '0;
            tmo_cnt <= '0;
        end else if (wb_cyc) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (wb_stb && !wb_stall) begin
                wb_stb  <= 1'b0;
                wb_wdat <= '0;
            end
        end
    end

endmodule

// File: rtl/wb_button_poller.sv
// Polls the button register every POLL_CYCLES idle cycles; count updates the cycle after read ack, write follows at once.
// Waits out slave stall and ack latency; a per-transaction ack timeout returns the FSM to IDLE.
module wb_button_poller #(
    parameter logic [31:0] ADDRESS        = 32'h00000001,
    parameter int          POLL_CYCLES    = 1000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data,
    output logic [7:0]  o_count,
    output logic        o_timeout,
    output logic        o_busy
);

    import wb_poller_pkg::*;

    localparam int PW = $clog2(POLL_CYCLES);

    poll_state_t   state, state_nxt;
    logic [PW-1:0] timer;
    logic [2:0]    prev, cur, rise;
    logic          primed;
    logic [7:0]    count, count_nxt;
    logic          start, start_we;
    logic [31:0]   start_wdata, rdata;
    logic          done, timeout, accepted, rd_done, poll_due;
    logic          unused_rdata;

    assign cur          = rdata[2:0];
    assign unused_rdata = ^rdata[31:3];
    assign rise         = cur & ~prev;
    assign count_nxt    = next_count(count, rise);
    assign poll_due     = enable && (timer == PW'(POLL_CYCLES - 1));
    assign accepted     = o_wb_stb && !i_wb_stall;
    assign rd_done      = done && (state == RD_REQ || state == RD_WAIT);
    assign o_wb_addr    = ADDRESS;
    assign o_count      = count;

    wb_single_master #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_master (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .we       (start_we),
        .wdata    (start_wdata),
        .done     (done),
        .rdata    (rdata),
        .timeout  (timeout),
        .wb_cyc   (o_wb_cyc),
        .wb_stb   (o_wb_stb),
        .wb_we    (o_wb_we),
        .wb_wdat  (o_wb_data),
        .wb_ack   (i_wb_ack),
        .wb_stall (i_wb_stall),
        .wb_rdat  (i_wb_data)
    );

    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        start_we    = 1'b0;
        start_wdata = '0;
        case (state)
            IDLE: begin
                if (poll_due) begin
                    start     = 1'b1;
                    state_nxt = RD_REQ;
                end
            end
            RD_REQ, RD_WAIT: begin
                // The first read after reset only primes the edge detector.
                if (done) begin
                    if (primed && (count_nxt != count)) begin
                        start       = 1'b1;
                        start_we    = 1'b1;
                        start_wdata = {24'd0, count_nxt};
                        state_nxt   = WR_REQ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (timeout) begin
                    state_nxt = IDLE;
                end else if (state == RD_REQ && accepted) begin
                    state_nxt = RD_WAIT;
                end
            end
            WR_REQ, WR_WAIT: begin
                if (done || timeout)
                    state_nxt = IDLE;
                else if (state == WR_REQ && accepted)
                    state_nxt = WR_WAIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= '0;
            prev      <= '0;
            primed    <= 1'b0;
            count     <= '0;
            o_timeout <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_busy    <= (state_nxt != IDLE);
            o_timeout <= timeout;
            if (state == IDLE && enable && !poll_due)
                timer <= timer + 1'b1;
            else
                timer <= '0;
            if (rd_done) begin
                prev   <= cur;
                primed <= 1'b1;
                if (primed)
                    count <= count_nxt;
            end
        end
    end

endmodule

// File: tb/tb_wb_button_poller.sv
// Bench for wb_button_poller: behavioural Wishbone slave plus a transaction-level count model.
module tb_wb_button_poller;

    localparam logic [31:0] ADDR = 32'h00000001;
    localparam int POLL = 8;
    localparam int TMO  = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_addr, o_wb_data;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_stall = 1'b0;
    logic [31:0] i_wb_data = '0;
    logic [7:0]  o_count;
    logic        o_timeout, o_busy;

    always #5 clk = ~clk;

    wb_button_poller #(
        .ADDRESS(ADDR),
        .POLL_CYCLES(POLL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .i_wb_ack   (i_wb_ack),
        .i_wb_stall (i_wb_stall),
        .i_wb_data  (i_wb_data),
        .o_count    (o_count),
        .o_timeout  (o_timeout),
        .o_busy     (o_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave state and bookkeeping
    logic [2:0]  buttons = 3'b000;
    int          stall_left = 0;
    int          lat_cfg = 1;
    bit          no_ack = 1'b0;
    int          ack_cnt = 0;
    bit          pend_we = 1'b0;
    bit          prev_stb = 1'b0;
    int          n_rd_ack = 0;
    int          n_wr = 0;
    int          n_tmo = 0;
    int          exp_tmo = 0;
    int          rd_stb_cyc = 0;
    int          tick = 0;
    int          rd_start = 0;
    int          rd_start_prev = 0;
    logic [31:0] last_wdat = '0;
    logic [31:0] last_addr = '0;

    initial begin
        forever begin
            @(negedge clk);
            tick++;
            if (o_timeout) n_tmo++;
            i_wb_ack  = 1'b0;
            i_wb_data = '0;
            if (!o_wb_cyc) begin
                ack_cnt = 0;
            end else if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    i_wb_ack = 1'b1;
                    if (!pend_we) begin
                        i_wb_data = ($urandom & 32'hFFFF_FFF8) | {29'd0, buttons};
                        n_rd_ack++;
                    end
                end
            end
            i_wb_stall = 1'b0;
            if (o_wb_stb) begin
                if (!o_wb_we) begin
                    rd_stb_cyc++;
                    if (!prev_stb) begin
                        rd_start_prev = rd_start;
                        rd_start      = tick;
                    end
                end
                if (stall_left > 0) begin
                    i_wb_stall = 1'b1;
                    stall_left--;
                end else begin
                    last_addr = o_wb_addr;
                    pend_we   = o_wb_we;
                    if (!no_ack) ack_cnt = lat_cfg;
                    if (o_wb_we) begin
                        n_wr++;
                        last_wdat = o_wb_data;
                    end
                end
            end
            prev_stb = o_wb_stb;
        end
    end

    // Reference model: what one completed read should do to the counter.
    bit         m_primed = 1'b0;
    logic [2:0] m_prev = 3'b000;
    int         m_count = 0;

    task automatic model_read(input logic [2:0] cur, output bit wr, output logic [7:0] val);
        int  old;
        bit  up, dn, clr;
        old = m_count;
        wr  = 1'b0;
        if (m_primed) begin
            clr = cur[2] && !m_prev[2];
            up  = cur[0] && !m_prev[0];
            dn  = cur[1] && !m_prev[1];
            if (clr)           m_count = 0;
            else if (up && !dn) m_count = (m_count + 1) % 256;
            else if (dn && !up) m_count = (m_count + 255) % 256;
            wr = (m_count != old);
        end
        m_primed = 1'b1;
        m_prev   = cur;
        val      = m_count[7:0];
    endtask

    task automatic wait_cyc(output bit got);
        got = 1'b0;
        for (int i = 0; i < POLL + 20; i++) begin
            @(negedge clk);
            if (o_wb_cyc) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic poll_once(input logic [2:0] b, input int st, input int lat, input bit drop_en);
        bit         got, wr;
        logic [7:0] v;
        int         rd0, wr0;
        buttons = b; stall_left = st; lat_cfg = lat; rd_stb_cyc = 0;
        rd0 = n_rd_ack; wr0 = n_wr;
        wait_cyc(got);
        chk_eq("poll_start", got, 1);
        if (drop_en) enable = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (n_rd_ack != rd0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk_eq("read_ack_seen", got, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!o_busy) break;
        end
        chk_eq("busy_after_poll", o_busy, 0);
        model_read(b, wr, v);
        chk_eq("write_count", n_wr - wr0, wr);
        if (wr) chk_eq("write_data", last_wdat, {24'd0, v});
        chk_eq("count", o_count, m_count);
        chk_eq("read_stb_cycles", rd_stb_cyc, st + 1);
        chk_eq("bus_addr", last_addr, ADDR);
        if (drop_en) begin
            repeat (2 * POLL) @(negedge clk);
            chk_eq("no_poll_disabled", n_rd_ack - rd0, 1);
            enable = 1'b1;
        end
    endtask

    task automatic poll_traced(input logic [2:0] b);
        bit         got, wr;
        logic [7:0] v;
        int         wr0;
        buttons = b; stall_left = 0; lat_cfg = 1; wr0 = n_wr;
        wait_cyc(got);
        chk_eq("tr_start", got, 1);
        model_read(b, wr, v);
        chk_eq("tr_T0_ctl", {o_wb_cyc, o_wb_stb, o_wb_we}, 3'b110);
        chk_eq("tr_T0_data", o_wb_data, 0);
        @(negedge clk);
        chk_eq("tr_T1_ctl", {o_wb_cyc, o_wb_stb, o_wb_we}, 3'b100);
        @(negedge clk);
        chk_eq("tr_T2_ctl", {o_wb_cyc, o_wb_stb, o_wb_we}, 3'b111);
        chk_eq("tr_T2_data", o_wb_data, {24'd0, v});
        chk_eq("tr_T2_count", o_count, v);
        @(negedge clk);
        chk_eq("tr_T3_ctl", {o_wb_cyc, o_wb_stb, o_wb_we}, 3'b101);
        @(negedge clk);
        chk_eq("tr_T4_ctl", {o_wb_cyc, o_wb_stb, o_wb_we, o_busy}, 4'b0000);
        chk_eq("tr_writes", n_wr - wr0, wr);
    endtask

    task automatic poll_timeout(input logic [2:0] b);
        bit got;
        int n, t0, wr0;
        buttons = b; stall_left = 0; no_ack = 1'b1;
        t0 = n_tmo; wr0 = n_wr;
        wait_cyc(got);
        chk_eq("tmo_start", got, 1);
        n = 0;
        do begin
            n++;
            @(negedge clk);
        end while (o_wb_cyc && n < 50);
        chk_eq("tmo_cyc_len", n, TMO);
        chk_eq("tmo_pulse_now", {o_wb_cyc, o_wb_stb, o_timeout, o_busy}, 4'b0010);
        repeat (3) @(negedge clk);
        chk_eq("tmo_pulses", n_tmo - t0, 1);
        chk_eq("tmo_count", o_count, m_count);
        chk_eq("tmo_writes", n_wr - wr0, 0);
        no_ack = 1'b0;
        exp_tmo++;
    endtask

    initial begin
        bit got;
        #12;
        chk_eq("rst_ctl", {o_wb_cyc, o_wb_stb, o_wb_we, o_timeout, o_busy}, 5'b00000);
        chk_eq("rst_data", o_wb_data, 0);
        chk_eq("rst_count", o_count, 0);
        chk_eq("rst_addr", o_wb_addr, ADDR);
        @(negedge clk);
        reset = 1'b1;

        poll_once(3'b001, 0, 1, 0);
        poll_once(3'b000, 0, 1, 0);
        poll_once(3'b010, 0, 1, 0);
        poll_once(3'b000, 0, 1, 0);
        poll_traced(3'b001);

        poll_once(3'b000, 0, 1, 0);
        poll_once(3'b011, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            poll_once(3'b000, 0, 1, 0);
            poll_once(3'b001, 0, 1, 0);
        end
        poll_once(3'b000, 0, 1, 0);
        poll_once(3'b101, 0, 1, 0);
        poll_once(3'b000, 0, 1, 0);
        poll_once(3'b010, 0, 1, 0);

        poll_once(3'b000, 3, 1, 0);
        poll_once(3'b001, 3, 1, 0);

        poll_once(3'b001, 0, 1, 0);
        poll_once(3'b001, 0, 1, 0);
        chk_eq("poll_period", rd_start - rd_start_prev, POLL + 2);

        poll_once(3'b000, 0, 1, 0);
        poll_timeout(3'b001);
        poll_once(3'b001, 0, 1, 0);

        poll_once(3'b000, 0, 1, 0);
        buttons = 3'b001; lat_cfg = 3;
        got = 1'b0;
        for (int i = 0; i < POLL + 30; i++) begin
            @(negedge clk);
            if (o_wb_cyc && o_wb_we && !o_wb_stb) begin
                got = 1'b1;
                break;
            end
        end
        chk_eq("rstw_reached", got, 1);
        reset = 1'b0;
        #1;
        chk_eq("rstw_ctl", {o_wb_cyc, o_wb_stb, o_wb_we, o_timeout, o_busy}, 5'b00000);
        chk_eq("rstw_data", o_wb_data, 0);
        chk_eq("rstw_count", o_count, 0);
        m_primed = 1'b0; m_prev = 3'b000; m_count = 0;
        @(negedge clk);
        reset = 1'b1;
        poll_once(3'b011, 0, 1, 0);

        for (int k = 0; k < 40; k++)
            poll_once(3'($urandom_range(0, 7)), $urandom_range(0, 2), $urandom_range(1, 2),
                      ($urandom_range(0, 7) == 0));

        chk_eq("total_timeouts", n_tmo, exp_tmo);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
